// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART constants and helpers for the TX FIFO slice.
// Status feature of uart_tx_fifo is enabled by defining UART_TX_FIFO_STATUS_EN.
package uart_tx_fifo_pkg;

  localparam int unsigned UART_DATA_W      = 8;
  localparam int unsigned UART_FIFO_ADDR_W = 4;

  // Receiver oversampling and stop-bit tick counts (1 and 2 stop bits).
  localparam int unsigned UART_OVERSAMPLE   = 16;
  localparam int unsigned UART_STOP_TICKS_1 = 16;
  localparam int unsigned UART_STOP_TICKS_2 = 32;

  typedef enum logic [1:0] {
    ParityNone = 2'd0,
    ParityOdd  = 2'd1,
    ParityEven = 2'd2
  } uart_parity_e;

  function automatic int unsigned fifo_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/uart_fifo_ctrl.sv
// Pointer, full/empty and optional status bookkeeping for the UART TX FIFO.
// Status counter/flags are built only when UART_TX_FIFO_STATUS_EN is defined.
module uart_fifo_ctrl
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned ADDR_W = UART_FIFO_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_wr,
  input  logic              i_rd,
  output logic [ADDR_W-1:0] o_w_addr,
  output logic [ADDR_W-1:0] o_r_addr,
  output logic              o_wr_accept,
  output logic              o_empty,
  output logic              o_full,
  output logic [ADDR_W:0]   o_level,
  output logic              o_ovf,
  output logic              o_udf
);

  logic [ADDR_W-1:0] r_w_ptr;
  logic [ADDR_W-1:0] r_r_ptr;
  logic              r_empty;
  logic              r_full;

  logic [ADDR_W-1:0] w_w_ptr_inc;
  logic [ADDR_W-1:0] w_r_ptr_inc;
  logic              w_wr_acc;
  logic              w_rd_acc;

  // A pop in the same cycle frees a slot, so a write while full is still taken.
  assign w_wr_acc    = i_wr & (~r_full | i_rd);
  assign w_rd_acc    = i_rd & ~r_empty;
  assign w_w_ptr_inc = r_w_ptr + ADDR_W'(1);
  assign w_r_ptr_inc = r_r_ptr + ADDR_W'(1);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_w_ptr <= '0;
      r_r_ptr <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      if (w_wr_acc) r_w_ptr <= w_w_ptr_inc;
      if (w_rd_acc) r_r_ptr <= w_r_ptr_inc;
      case ({w_wr_acc, w_rd_acc})
        2'b10: begin
          r_empty <= 1'b0;
          r_full  <= (w_w_ptr_inc == r_r_ptr);
        end
        2'b01: begin
          r_full  <= 1'b0;
          r_empty <= (w_r_ptr_inc == r_w_ptr);
        end
        default: begin
        end
      endcase
    end
  end

  assign o_w_addr    = r_w_ptr;
  assign o_r_addr    = r_r_ptr;
  assign o_wr_accept = w_wr_acc;
  assign o_empty     = r_empty;
  assign o_full      = r_full;

`ifdef UART_TX_FIFO_STATUS_EN
  logic [ADDR_W:0] r_level;
  logic            r_ovf;
  logic            r_udf;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_level <= r_level + (ADDR_W + 1)'(1);
        2'b01:   r_level <= r_level - (ADDR_W + 1)'(1);
        default: r_level <= r_level;
      endcase
      if (i_wr && !w_wr_acc) r_ovf <= 1'b1;
      if (i_rd && !w_rd_acc) r_udf <= 1'b1;
    end
  end

  assign o_level = r_level;
  assign o_ovf   = r_ovf;
  assign o_udf   = r_udf;
`else
  assign o_level = '0;
  assign o_ovf   = 1'b0;
  assign o_udf   = 1'b0;
`endif

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through buffer feeding the UART transmitter; pop on tx_done_tick.
// Optional level/ovf/udf status is enabled by defining UART_TX_FIFO_STATUS_EN.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = UART_DATA_W,
  parameter int unsigned ADDR_W = UART_FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              rd,
  output logic [DATA_W-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              ovf,
  output logic              udf
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_W);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] w_w_addr;
  logic [ADDR_W-1:0] w_r_addr;
  logic              w_wr_accept;

  uart_fifo_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_ctrl (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_wr        (wr),
    .i_rd        (rd),
    .o_w_addr    (w_w_addr),
    .o_r_addr    (w_r_addr),
    .o_wr_accept (w_wr_accept),
    .o_empty     (empty),
    .o_full      (full),
    .o_level     (level),
    .o_ovf       (ovf),
    .o_udf       (udf)
  );

  // Storage is cleared on reset so r_data reads 0 immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_accept) begin
      r_mem[w_w_addr] <= w_data;
    end
  end

  assign r_data = r_mem[w_r_addr];

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised self-checking bench for uart_tx_fifo against a queue-based model.
// Status expectations follow UART_TX_FIFO_STATUS_EN.
module tb_uart_tx_fifo;

`ifdef UART_TX_FIFO_STATUS_EN
  localparam bit STATUS = 1'b1;
`else
  localparam bit STATUS = 1'b0;
`endif
  localparam int DEPTH = 16;

  logic       clk;
  logic       reset_n;
  logic       wr;
  logic [7:0] w_data;
  logic       rd;
  logic [7:0] r_data;
  logic       empty;
  logic       full;
  logic [4:0] level;
  logic       ovf;
  logic       udf;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] q[$];
  bit         ovf_m;
  bit         udf_m;

  uart_tx_fifo #(
    .DATA_W (8),
    .ADDR_W (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wr      (wr),
    .w_data  (w_data),
    .rd      (rd),
    .r_data  (r_data),
    .empty   (empty),
    .full    (full),
    .level   (level),
    .ovf     (ovf),
    .udf     (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic compare(input string tag);
    check({tag, ":empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, ":full"}, 32'(full), 32'(q.size() == DEPTH));
    if (q.size() > 0) check({tag, ":r_data"}, 32'(r_data), 32'(q[0]));
    check({tag, ":level"}, 32'(level), STATUS ? 32'(q.size()) : 32'd0);
    check({tag, ":ovf"}, 32'(ovf), 32'(ovf_m));
    check({tag, ":udf"}, 32'(udf), 32'(udf_m));
  endtask

  // One clock cycle of stimulus; the model applies the queue semantics directly.
  task automatic step(input string tag, input bit w, input logic [7:0] d, input bit r);
    bit wa;
    bit ra;
    @(negedge clk);
    wr     = w;
    w_data = d;
    rd     = r;
    @(posedge clk);
    wa = w && (q.size() < DEPTH || r);
    ra = r && (q.size() > 0);
    if (ra) void'(q.pop_front());
    if (wa) q.push_back(d);
    if (STATUS && w && !wa) ovf_m = 1'b1;
    if (STATUS && r && !ra) udf_m = 1'b1;
    #1;
    wr = 1'b0;
    rd = 1'b0;
    compare(tag);
  endtask

  // Assert reset between edges and check the outputs clear without a clock edge.
  task automatic mid_reset(input string tag);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    q.delete();
    ovf_m = 1'b0;
    udf_m = 1'b0;
    #1;
    compare(tag);
    check({tag, ":r_data0"}, 32'(r_data), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    wr      = 1'b0;
    rd      = 1'b0;
    w_data  = '0;
    reset_n = 1'b0;
    ovf_m   = 1'b0;
    udf_m   = 1'b0;
    #12;
    compare("reset");
    check("reset:r_data0", 32'(r_data), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Short burst then drain.
    step("t1_wr", 1, 8'h41, 0);
    step("t1_wr", 1, 8'h42, 0);
    step("t1_wr", 1, 8'h43, 0);
    for (int i = 0; i < 3; i++) step("t1_rd", 0, 8'h00, 1);

    // Fill to full, overflow attempt, drain in order.
    for (int i = 0; i < DEPTH; i++) step("t2_fill", 1, 8'(i), 0);
    step("t2_ovf", 1, 8'hFF, 0);
    for (int i = 0; i < DEPTH; i++) step("t2_drain", 0, 8'h00, 1);

    // Simultaneous write and pop while full.
    for (int i = 0; i < DEPTH; i++) step("t3_fill", 1, 8'(8'h80 + i), 0);
    step("t3_both", 1, 8'h55, 1);
    for (int i = 0; i < DEPTH; i++) step("t3_drain", 0, 8'h00, 1);

    // Underflow, then write and pop together while empty.
    step("t4_udf", 0, 8'h00, 1);
    step("t4_both", 1, 8'h30, 1);
    step("t4_rd", 0, 8'h00, 1);

    // Interleaved stream around the pointer wrap.
    step("t5_first", 1, 8'h00, 0);
    for (int i = 1; i < 40; i++) step("t5_stream", 1, 8'(i), 1);
    step("t5_last", 0, 8'h00, 1);

    // Reset mid-burst.
    for (int i = 0; i < 5; i++) step("t6_fill", 1, 8'(8'hA0 + i), 0);
    mid_reset("t6_reset");

    // Random phases with different write/pop pressure.
    for (int ph = 0; ph < 4; ph++) begin
      int pw;
      int pr;
      pw = (ph == 0) ? 80 : (ph == 1) ? 30 : (ph == 2) ? 60 : 95;
      pr = (ph == 0) ? 30 : (ph == 1) ? 80 : (ph == 2) ? 60 : 95;
      for (int i = 0; i < 150; i++) begin
        step("rand", ($urandom_range(99, 0) < pw), 8'($urandom), ($urandom_range(99, 0) < pr));
      end
    end
    mid_reset("rand_reset");
    step("post_reset", 1, 8'h5A, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
